bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Iterative binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
- Processes one bit per clock and is parametrised in input width and BCD digit count.
- Uses a start/busy/done handshake.
- Feeds the 7-segment display path; replaces fixed-width combinational add-3 chains.

Parameters:
- BIN_W, 8, width of the binary input (>=2).
- DIGITS, 3, number of BCD output digits (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled in IDLE or DONE only.
- bin_in  in  BIN_W  binary operand; captured on the accepted start.
- busy  out  1  high while converting.
- done  out  1  one-cycle pulse when the result becomes valid.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]; held until the next accepted start completes.
- overflow  out  1  high with the result when the value exceeds 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, bit counter=0, shift register=0.
- FSM states: IDLE, CONV, DONE.
- IDLE, start=1: capture bin_in into the binary shift register, clear the BCD working register and overflow accumulator, load counter=BIN_W-1, go to CONV.
- IDLE, start=0: stay in IDLE.
- CONV, each cycle:
  - every working digit >=5 gets +3 (4-bit, no carry out of the digit);
  - then {bcd_work, bin_shift} shifts left 1;
  - the bit leaving the top digit ORs into the overflow accumulator.
- CONV exit: when counter==0 after that cycle's shift, go to DONE. Otherwise decrement the counter.
- DONE: bcd_out<=bcd_work, overflow<=accumulator, done=1 for exactly this cycle.
  - start=1 here: accepted exactly as in IDLE (back-to-back conversions).
  - otherwise: go to IDLE.
- Latency: start sampled at edge N; busy=1 from N+1 for BIN_W cycles; done=1 in cycle N+BIN_W+1.
  - Throughput: one conversion per BIN_W+1 cycles.
- busy=1 exactly while in CONV.
- start while busy: ignored; bin_in is not re-sampled.
- bcd_out and overflow change only in the DONE cycle. Intermediate values are never visible.
- Digits with DIGITS larger than required read 0.
- Reset mid-conversion: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - On accept, the magnitude |bin_in| (BIN_W bits, unsigned) is loaded into the shift register.
  - Extra output port sign_out (1 bit, reset 0) is updated in the DONE cycle with bin_in[BIN_W-1] as captured at start.
  - The most negative value converts to magnitude 2^(BIN_W-1).
- Undefined: input is unsigned and the sign_out port is absent.

Decomposition:
- Package bin2bcd_pkg:
  - state enum (IDLE, CONV, DONE);
  - function bcd_digits_for(width) = number of decimal digits of 2^width-1, for instantiation-time DIGITS checks;
  - localparam for the +3 threshold (5).
- Sub-module bcd_add3_cell: combinational 4-bit digit corrector; input >=5 -> input+3, else passthrough; values 10..15 -> 0.
- Instantiated DIGITS times via generate.

Test Plan:
- BIN_W=8, DIGITS=3, bin_in=255, start pulse:
  - busy high 8 cycles;
  - done at cycle 9;
  - bcd_out=12'h255, overflow=0.
- bin_in=0 then bin_in=99 back-to-back, with start held high through DONE:
  - results 12'h000 then 12'h099;
  - second done pulse exactly 9 cycles after the first.
- BIN_W=8, DIGITS=2, bin_in=255 -> bcd_out=8'h55, overflow=1. Then bin_in=42 -> 8'h42, overflow=0.
- Start 200; pulse start with bin_in=7 at cycle 3 of CONV -> ignored; result 12'h200, single done pulse.
- Start 123; assert rst_n=0 during CONV cycle 4 -> outputs immediately 0. No done pulse after release; a subsequent start of 123 -> 12'h123.
- BIN2BCD_SIGNED_EN, BIN_W=8, DIGITS=3:
  - bin_in=8'h80 -> bcd_out=12'h128, sign_out=1;
  - bin_in=8'h7F -> 12'h127, sign_out=0.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  // Digits at or above this value get +3 before each doubling step.
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Number of decimal digits needed to show 2^width-1 (width < 64).
  function automatic int unsigned bcd_digits_for(input int unsigned width);
    longint unsigned limit;
    longint unsigned pow10;
    int unsigned     n;
    limit = (64'd1 << width) - 64'd1;
    pow10 = 64'd10;
    n     = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      if (pow10 <= limit) begin
        n++;
        pow10 = pow10 * 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Single-digit double-dabble corrector: >=5 gets +3, invalid codes 10..15 read as 0.
module bcd_add3_cell
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    if (digit_in > 4'd9) begin
      digit_out = '0;
    end else if (digit_in >= ADD3_THRESH) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGNED_EN for two's-complement input and the sign_out port.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign_out
`endif
);

  localparam int unsigned BCD_W      = 4 * DIGITS;
  localparam int unsigned CNT_W      = $clog2(BIN_W);
  localparam logic        FULL_RANGE = (DIGITS >= bcd_digits_for(BIN_W));

  if (BIN_W < 2 || DIGITS < 1) begin : g_bad_params
    $error("bin2bcd_seq: BIN_W must be >= 2 and DIGITS >= 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_shift_q, bin_shift_d;
  logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   load_val;
  logic               accept;
  logic               finish;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .digit_in  (bcd_work_q[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  assign load_val = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
`else
  assign load_val = bin_in;
`endif

  assign accept = start && (state_q != CONV);
  assign finish = (state_q == CONV) && (cnt_q == '0);

  // Outputs are registered on the final CONV edge so they are valid
  // throughout the DONE cycle, matching the done pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_shift_d = bin_shift_q;
    bcd_work_d  = bcd_work_q;
    ovf_acc_d   = ovf_acc_q;
    bcd_out_d   = bcd_out_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d     = CONV;
          bin_shift_d = load_val;
          bcd_work_d  = '0;
          ovf_acc_d   = 1'b0;
          cnt_d       = CNT_W'(BIN_W - 1);
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        {bcd_work_d, bin_shift_d} = {bcd_adj, bin_shift_q} << 1;
        ovf_acc_d = FULL_RANGE ? 1'b0 : (ovf_acc_q | bcd_adj[BCD_W-1]);
        if (finish) begin
          state_d    = DONE;
          done_d     = 1'b1;
          bcd_out_d  = bcd_work_d;
          overflow_d = ovf_acc_d;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CONV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_shift_q <= '0;
      bcd_work_q  <= '0;
      ovf_acc_q   <= 1'b0;
      bcd_out_q   <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_shift_q <= bin_shift_d;
      bcd_work_q  <= bcd_work_d;
      ovf_acc_q   <= ovf_acc_d;
      bcd_out_q   <= bcd_out_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_cap_q, sign_cap_d;
  logic sign_out_q, sign_out_d;

  always_comb begin
    sign_cap_d = sign_cap_q;
    sign_out_d = sign_out_q;
    if (accept) sign_cap_d = bin_in[BIN_W-1];
    if (finish) sign_out_d = sign_cap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_cap_q <= 1'b0;
      sign_out_q <= 1'b0;
    end else begin
      sign_cap_q <= sign_cap_d;
      sign_out_q <= sign_out_d;
    end
  end

  assign sign_out = sign_out_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: DIGITS=3 and DIGITS=2 instances against a decimal-arithmetic model.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [7:0]  bin_in = '0;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
`ifdef BIN2BCD_SIGNED_EN
  logic        sgn3, sgn2;
`endif

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sgn3)
`endif
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
`ifdef BIN2BCD_SIGNED_EN
    , .sign_out(sgn2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, overflow by magnitude compare.
  function automatic logic [11:0] to_bcd(input int v, input int d);
    logic [11:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int mag(input logic [7:0] b);
`ifdef BIN2BCD_SIGNED_EN
    return b[7] ? (256 - int'(b)) : int'(b);
`else
    return int'(b);
`endif
  endfunction

  int          m_left;
  int          m_val;
  logic        m_sgn_cap;
  logic        m_done;
  logic [11:0] m_bcd3;
  logic        m_ovf3;
  logic [7:0]  m_bcd2;
  logic        m_ovf2;
  logic        m_sign;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left    <= 0;
      m_val     <= 0;
      m_sgn_cap <= 1'b0;
      m_done    <= 1'b0;
      m_bcd3    <= '0;
      m_ovf3    <= 1'b0;
      m_bcd2    <= '0;
      m_ovf2    <= 1'b0;
      m_sign    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left    <= BIN_W;
          m_val     <= mag(bin_in);
          m_sgn_cap <= bin_in[7];
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_bcd3 <= to_bcd(m_val, 3);
          m_ovf3 <= (m_val > 999);
          m_bcd2 <= 8'(to_bcd(m_val, 2));
          m_ovf2 <= (m_val > 99);
          m_sign <= m_sgn_cap;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy3",    32'(busy3), 32'(m_left > 0));
    check("done3",    32'(done3), 32'(m_done));
    check("bcd3",     32'(bcd3),  32'(m_bcd3));
    check("ovf3",     32'(ovf3),  32'(m_ovf3));
    check("busy2",    32'(busy2), 32'(m_left > 0));
    check("done2",    32'(done2), 32'(m_done));
    check("bcd2",     32'(bcd2),  32'(m_bcd2));
    check("ovf2",     32'(ovf2),  32'(m_ovf2));
`ifdef BIN2BCD_SIGNED_EN
    check("sign3",    32'(sgn3),  32'(m_sign));
    check("sign2",    32'(sgn2),  32'(m_sign));
`endif
    if (done3) n_done++;
  end

  // Called on a negedge; returns on the negedge where done is seen.
  task automatic run(input logic [7:0] v, output int cyc, output int busyc);
    bin_in = v;
    start  = 1'b1;
    cyc    = 0;
    busyc  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 0) start = 1'b0;
      if (busy3) busyc++;
      if (done3) break;
    end
    if (!done3) check("done_timeout", 32'(done3), 32'd1);
  endtask

  initial begin
    int   cyc, busyc, d0;
    logic [7:0] pick [6];
    pick[0] = 8'd0;   pick[1] = 8'd255; pick[2] = 8'd128;
    pick[3] = 8'd99;  pick[4] = 8'd100; pick[5] = 8'd127;

    repeat (3) @(negedge clk);
    check("rst_bcd3", 32'(bcd3), 32'h0);
    check("rst_busy", 32'(busy3), 32'h0);
    check("rst_done", 32'(done3), 32'h0);
    check("rst_ovf2", 32'(ovf2), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single conversion: latency and busy length
    run(8'd255, cyc, busyc);
    check("latency", 32'(cyc), 32'd9);
    check("busy_len", 32'(busyc), 32'd8);
`ifndef BIN2BCD_SIGNED_EN
    check("lit_255_d3", 32'(bcd3), 32'h255);
    check("lit_255_o3", 32'(ovf3), 32'h0);
    check("lit_255_d2", 32'(bcd2), 32'h55);
    check("lit_255_o2", 32'(ovf2), 32'h1);
`endif
    repeat (2) @(negedge clk);
    run(8'd42, cyc, busyc);
    check("lit_42_d2", 32'(bcd2), 32'h42);
    check("lit_42_o2", 32'(ovf2), 32'h0);
    repeat (2) @(negedge clk);

    // Back-to-back with start held through DONE
    bin_in = 8'd0;
    start  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done3) break;
    end
    check("b2b_first_done", 32'(done3), 32'd1);
    check("lit_0_d3", 32'(bcd3), 32'h000);
    bin_in = 8'd99;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 0) start = 1'b0;
      if (done3) break;
    end
    check("b2b_spacing", 32'(cyc), 32'd9);
    check("lit_99_d3", 32'(bcd3), 32'h099);
    repeat (2) @(negedge clk);

    // Start during CONV is ignored
    d0 = n_done;
    bin_in = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bin_in = 8'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (20) @(negedge clk);
    check("ignore_one_done", 32'(n_done - d0), 32'd1);
`ifndef BIN2BCD_SIGNED_EN
    check("lit_200_d3", 32'(bcd3), 32'h200);
`endif

    // Reset in CONV cycle 4
    bin_in = 8'd123;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy3), 32'h0);
    check("rst_mid_bcd3", 32'(bcd3), 32'h0);
    check("rst_mid_ovf2", 32'(ovf2), 32'h0);
    d0 = n_done;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_no_done", 32'(n_done - d0), 32'd0);
    run(8'd123, cyc, busyc);
    check("lit_123_d3", 32'(bcd3), 32'h123);
    repeat (2) @(negedge clk);

`ifdef BIN2BCD_SIGNED_EN
    run(8'h80, cyc, busyc);
    check("lit_m128_d3", 32'(bcd3), 32'h128);
    check("lit_m128_s", 32'(sgn3), 32'h1);
    repeat (2) @(negedge clk);
    run(8'h7F, cyc, busyc);
    check("lit_127_d3", 32'(bcd3), 32'h127);
    check("lit_127_s", 32'(sgn3), 32'h0);
    repeat (2) @(negedge clk);
`endif

    // Random traffic, occasional async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) bin_in = pick[$urandom_range(0, 5)];
      else bin_in = 8'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
